// File: rtl/alu_sequencer.sv
// Accumulator front end for the 6-bit combinational ALU: accepts one instruction,
// registers operands for one EXEC cycle, captures the result and returns it over valid/ready.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] instr_op,
  input  logic [5:0] instr_operand,
  input  logic       instr_wb,
  output logic [5:0] alu_a,
  output logic [5:0] alu_b,
  output logic [2:0] alu_control,
  input  logic [5:0] alu_c,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [5:0] rsp_data,
  output logic       rsp_zero,
  output logic [7:0] retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] acc;
  logic [5:0] operand_q;
  logic [2:0] op_q;
  logic       wb_q;
  logic       accept;
  logic       complete;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      operand_q <= '0;
      op_q      <= '0;
      wb_q      <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      retired   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q      <= instr_op;
        operand_q <= instr_operand;
        wb_q      <= instr_wb;
      end
      if (state == EXEC) begin
        rsp_data <= alu_c;
        rsp_zero <= (alu_c == '0);
        if (wb_q) acc <= alu_c;
      end
      if (complete) retired <= retired + 8'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    rsp_valid   = 1'b0;
    accept      = 1'b0;
    complete    = 1'b0;
    case (state)
      IDLE: begin
        // Ready is masked by rst so nothing appears accepted while reset is held.
        instr_ready = !rst;
        if (instr_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign alu_a       = acc;
  assign alu_b       = operand_q;
  assign alu_control = op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural model of the 6-bit ALU.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [5:0] instr_operand;
  logic       instr_wb;
  logic [5:0] alu_a;
  logic [5:0] alu_b;
  logic [2:0] alu_control;
  logic [5:0] alu_c;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [5:0] rsp_data;
  logic       rsp_zero;
  logic [7:0] retired;

  int checks   = 0;
  int failures = 0;
  int nrsp     = 0;
  logic [6:0] expq[$];

  alu_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_operand(instr_operand), .instr_wb(instr_wb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_c(alu_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .retired(retired)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_control)
      3'b000:  alu_c = alu_a + alu_b;
      3'b001:  alu_c = alu_a - alu_b;
      3'b010:  alu_c = {5'b0, alu_a == alu_b};
      3'b011:  alu_c = alu_a & alu_b;
      3'b100:  alu_c = alu_a | alu_b;
      3'b101:  alu_c = alu_a ^ alu_b;
      3'b110:  alu_c = alu_b;
      default: alu_c = alu_a;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed response handshake pops one expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      nrsp++;
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got data 0x%0h with no instruction outstanding", rsp_data);
      end else begin
        logic [6:0] e;
        e = expq.pop_front();
        if ({rsp_zero, rsp_data} !== e) begin
          failures++;
          $display("FAIL rsp: got data 0x%0h zero %0b expected data 0x%0h zero %0b",
                   rsp_data, rsp_zero, e[5:0], e[6]);
        end
      end
    end
  end

  // Caller is at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [5:0] opnd, input logic wb,
                       input logic push, input logic [5:0] exp_data);
    bit done = 0;
    instr_op      = op;
    instr_operand = opnd;
    instr_wb      = wb;
    instr_valid   = 1'b1;
    if (push) expq.push_back({exp_data == 6'd0, exp_data});
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (instr_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    instr_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got instr_ready 0 expected 1 within 20 cycles");
    end
  endtask

  task automatic wait_rsp(input int n0);
    bit done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      @(posedge clk);
      if (nrsp > n0) done = 1;
    end
    #1;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout: got %0d responses expected %0d", nrsp, n0 + 1);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [5:0] opnd, input logic wb,
                     input logic [5:0] exp_data);
    int n0;
    n0 = nrsp;
    issue(op, opnd, wb, 1'b1, exp_data);
    wait_rsp(n0);
  endtask

  task automatic check_reset_outputs(input logic exp_ready);
    check("rst_instr_ready", instr_ready, exp_ready);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_control", alu_control, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_zero", rsp_zero, 0);
    check("rst_retired", retired, 0);
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_op = '0;
    instr_operand = '0;
    instr_wb = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs(1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", instr_ready, 1);
    @(posedge clk); #1;

    // Load, add with wrap, subtract to zero
    run(3'b110, 6'd5, 1'b1, 6'd5);
    check("load_alu_a", alu_a, 5);
    check("load_retired", retired, 1);
    run(3'b000, 6'd60, 1'b1, 6'd1);
    check("add_wrap_acc", alu_a, 1);
    run(3'b001, 6'd1, 1'b1, 6'd0);
    check("sub_zero_acc", alu_a, 0);

    // eq without writeback, then xor
    run(3'b110, 6'h2A, 1'b1, 6'h2A);
    run(3'b010, 6'h2A, 1'b0, 6'd1);
    check("eq_no_wb_acc", alu_a, 6'h2A);
    run(3'b101, 6'h3F, 1'b1, 6'h15);
    check("xor_acc", alu_a, 6'h15);

    // and / or / pass a, no writeback
    run(3'b011, 6'h0F, 1'b0, 6'h05);
    run(3'b100, 6'h28, 1'b0, 6'h3D);
    run(3'b111, 6'h00, 1'b0, 6'h15);
    check("pass_a_retired", retired, 9);

    // Backpressure with a second instruction pending
    rsp_ready = 1'b0;
    n0 = nrsp;
    issue(3'b000, 6'd1, 1'b0, 1'b1, 6'h16);
    instr_op = 3'b110;
    instr_operand = 6'h3F;
    instr_wb = 1'b1;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, 6'h16);
      check("bp_instr_ready", instr_ready, 0);
      check("bp_alu_b", alu_b, 1);
    end
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_rsp(n0);
    check("bp_retired", retired, 10);
    check("bp_acc", alu_a, 6'h15);
    @(negedge clk);
    check("bp_no_second_accept", rsp_valid, 0);
    @(posedge clk); #1;

    // Reset asserted during EXEC
    n0 = nrsp;
    issue(3'b110, 6'h33, 1'b1, 1'b0, 6'h00);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs(1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_response", nrsp, n0);
    check("rst_retired_after", retired, 0);

    // 256 instructions: retired wraps to 0
    n0 = nrsp;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = i[7:0];
      run(3'b110, iv[5:0], 1'b0, iv[5:0]);
    end
    check("wrap_retired", retired, 0);
    check("wrap_count", nrsp - n0, 256);
    check("queue_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
